// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready on both sides.
// Per-word frame length and bit order; zero-bubble back-to-back frames.
module piso_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int BEATS      = DATA_WIDTH / LANES,
    parameter int LEN_W      = $clog2(BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LEN_W-1:0]      din_len,
    input  logic                  din_msb_first,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [LANES-1:0]      dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready,
    output logic                  busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [LEN_W-1:0] BEATS_L = LEN_W'(BEATS);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    logic [0:0]            state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [LEN_W-1:0]      remaining, remaining_n;
    logic                  msb_first, msb_first_n;
    logic [LEN_W-1:0]      eff_len;
    logic                  load, xfer;
    logic                  valid_n;
    logic [LANES-1:0]      dout_n;
    logic                  last_n;

    assign din_ready = !reset && ((state == IDLE) || (state == SHIFT && dout_last && dout_ready));
    assign load      = din_valid && din_ready;
    assign xfer      = dout_valid && dout_ready;
    assign busy      = dout_valid;

    assign eff_len = (din_len == '0 || din_len > BEATS_L) ? BEATS_L : din_len;

    // Outputs are registered, so the next beat is derived from the next shift-register contents.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        remaining_n = remaining;
        msb_first_n = msb_first;
        if (load) begin
            state_n     = SHIFT;
            shreg_n     = din;
            remaining_n = eff_len;
            msb_first_n = din_msb_first;
        end else if (xfer) begin
            shreg_n     = msb_first ? (shreg << LANES) : (shreg >> LANES);
            remaining_n = remaining - ONE_L;
            if (remaining == ONE_L) begin
                state_n = IDLE;
            end
        end

        valid_n = (state_n == SHIFT);
        dout_n  = '0;
        last_n  = 1'b0;
        if (valid_n) begin
            dout_n = msb_first_n ? shreg_n[DATA_WIDTH-1 -: LANES] : shreg_n[LANES-1:0];
            last_n = (remaining_n == ONE_L);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            remaining  <= '0;
            msb_first  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            remaining  <= remaining_n;
            msb_first  <= msb_first_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            dout_last  <= last_n;
        end
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out serializer with valid/ready handshakes on both sides.
- Accepts a DATA_WIDTH word and emits it as a frame of LANES-bit beats.
- Frame length is set per word; bit order (LSB- or MSB-first) is set per word.
- Feeds the serial link transmitters; replaces the fixed 1-bit, fixed-length shifter that has no flow control.

Parameters:
- DATA_WIDTH, 16, parallel word width.
- LANES, 1, bits emitted per beat; must divide DATA_WIDTH.
- BEATS, DATA_WIDTH/LANES, derived: maximum beats per frame.
- LEN_W, $clog2(BEATS+1), derived: width of the length field.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  parallel word.
- din_len  input  LEN_W  beats to emit; 0 or any value >BEATS means BEATS.
- din_msb_first  input  1  1 = emit MSB end first; 0 = emit LSB end first.
- din_valid  input  1  word offered.
- din_ready  output  1  block can accept a word this cycle.
- dout  output  LANES  current beat.
- dout_valid  output  1  dout holds a valid beat.
- dout_last  output  1  current beat is the final beat of the frame.
- dout_ready  input  1  downstream accepts the beat.
- busy  output  1  a frame is in progress (same as dout_valid).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset (asynchronous assert, release synchronous to clk):
  - state=IDLE, shift register=0, remaining count=0, latched mode=0.
  - dout=0, dout_valid=0, dout_last=0, busy=0.
  - din_ready is 0 while reset is high. Inputs are ignored during reset.
- FSM states: IDLE, SHIFT.
- Handshakes:
  - Load fires on din_valid && din_ready.
  - Beat transfer fires on dout_valid && dout_ready.
- din_ready = (state==IDLE) || (state==SHIFT && dout_last && dout_ready). This gives zero-bubble back-to-back frames.
- IDLE to SHIFT on load:
  - Latch din, din_msb_first and the effective length (after clamping).
  - dout_valid goes high the next cycle. Load-to-first-beat latency is 1 cycle.
- In SHIFT:
  - LSB-first: dout = shreg[LANES-1:0]; on transfer, shreg shifts right by LANES with zero fill.
  - MSB-first: dout = shreg[DATA_WIDTH-1 -: LANES], lane bit order unchanged; on transfer, shreg shifts left by LANES with zero fill.
  - On transfer, remaining decrements. dout_last = (remaining==1).
- Stall (dout_valid && !dout_ready): dout, dout_last and all state hold stable. No beat is lost or duplicated.
- Last-beat transfer:
  - With a simultaneous load, reload and stay in SHIFT; the new frame's first beat appears the next cycle.
  - Otherwise go to IDLE.
- dout and dout_last are forced to 0 whenever dout_valid=0. Leftover bits from short frames must never be visible.
- A frame shorter than BEATS emits only the first din_len beats in the selected order; the remaining bits are discarded.
- Mode and length changes on din_* while a frame is in SHIFT have no effect; they are sampled only at load.
- Reset asserted mid-frame aborts the frame immediately. No partial frame resumes after release.
- Every output is driven from a register, except din_ready, which is combinational from state and dout_ready.

Test Plan:
- Reset, then load din=16'hA5C3, len=0, LSB-first, dout_ready=1 -> 16 beats, one per cycle, starting cycle+1: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; dout_last on beat 16 only; busy drops the cycle after.
- Same word, MSB-first -> beats 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
- LANES=4, din=16'h1234, len=3, MSB-first -> beats 4'h1, 4'h2, 4'h3, then dout_valid=0 and dout=0; 4'h4 is never emitted.
- Back-to-back: din_valid held high with words 16'h0001 then 16'h8000, LSB-first, len=0 -> 32 consecutive valid beats with no gap; din_ready high exactly on each dout_last transfer.
- Random dout_ready stalls (e.g. low on beats 3-5) -> dout held constant during the stall; the full frame is received intact; scoreboard matches.
- Assert reset at beat 7 of a 16-beat frame -> outputs go to 0 asynchronously; after release din_ready=1 and the next load starts a clean frame.
